// File: rtl/pcie_tlp_pkg.sv
// rtl/pcie_tlp_pkg.sv - shared PCIe CQ/CC descriptor field offsets, codes and helpers
// Purpose: request-type and completion-status codes, bit offsets of the UltraScale
//   128b dword-aligned CQ/CC descriptors, the completer FSM state type and a CC
//   descriptor builder. Shared with the configurator encoder/decoder.
// Ports: none (package).
package pcie_tlp_pkg;

  // CQ request types
  localparam logic [3:0] CQ_REQ_MEM_RD    = 4'b0000;
  localparam logic [3:0] CQ_REQ_MEM_WR    = 4'b0001;
  localparam logic [3:0] CQ_REQ_IO_RD     = 4'b0010;
  localparam logic [3:0] CQ_REQ_IO_WR     = 4'b0011;
  localparam logic [3:0] CQ_REQ_LOCKED_RD = 4'b0111;

  // CC completion status
  localparam logic [2:0] CC_STATUS_SC = 3'b000;
  localparam logic [2:0] CC_STATUS_UR = 3'b001;

  // CQ descriptor offsets
  localparam int CQ_DWCNT_LSB   = 64;
  localparam int CQ_REQTYPE_LSB = 75;
  localparam int CQ_REQID_LSB   = 80;
  localparam int CQ_TAG_LSB     = 96;
  localparam int CQ_TC_LSB      = 121;
  localparam int CQ_ATTR_LSB    = 124;
  localparam int CQ_TUSER_SOP   = 40;

  // CC descriptor offsets
  localparam int CC_LADDR_LSB  = 0;
  localparam int CC_BCNT_LSB   = 16;
  localparam int CC_DWCNT_LSB  = 32;
  localparam int CC_STATUS_LSB = 43;
  localparam int CC_REQID_LSB  = 48;
  localparam int CC_TAG_LSB    = 64;
  localparam int CC_CPLID_LSB  = 72;
  localparam int CC_TC_LSB     = 89;
  localparam int CC_ATTR_LSB   = 92;
  localparam int CC_DATA_LSB   = 96;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_CPL     = 2'd3
  } cq_state_e;

  // Single-beat CC descriptor plus payload dword. Byte count is 4 for both SC
  // and UR; UR carries no payload and a zero dword count.
  function automatic logic [127:0] build_cc_desc(
    input logic [6:0]  lower_addr,
    input logic        is_ur,
    input logic [15:0] req_id,
    input logic [7:0]  tag,
    input logic [15:0] cpl_id,
    input logic [2:0]  tc,
    input logic [2:0]  attr,
    input logic [31:0] data
  );
    logic [127:0] d;
    d = '0;
    d[CC_LADDR_LSB +: 7]   = lower_addr;
    d[CC_BCNT_LSB +: 13]   = 13'd4;
    d[CC_DWCNT_LSB +: 11]  = is_ur ? 11'd0 : 11'd1;
    d[CC_STATUS_LSB +: 3]  = is_ur ? CC_STATUS_UR : CC_STATUS_SC;
    d[CC_REQID_LSB +: 16]  = req_id;
    d[CC_TAG_LSB +: 8]     = tag;
    d[CC_CPLID_LSB +: 16]  = cpl_id;
    d[CC_TC_LSB +: 3]      = tc;
    d[CC_ATTR_LSB +: 3]    = attr;
    d[CC_DATA_LSB +: 32]   = is_ur ? 32'd0 : data;
    return d;
  endfunction

endpackage

// File: rtl/pcie_cq_reg_file.sv
// rtl/pcie_cq_reg_file.sv - NUM_REGS x 32b register file, byte-enable write, async read
// Purpose: register storage for the CQ completer.
// Ports: clk/resetn (sync active-low), wr_en/wr_addr/wr_be/wr_data write port,
//   rd_addr/rd_data asynchronous read port, regs_flat flattened register view.
module pcie_cq_reg_file #(
  parameter int NUM_REGS       = 16,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [3:0]                wr_be,
  input  logic [31:0]               wr_data,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]               rd_data,
  output logic [NUM_REGS*32-1:0]    regs_flat
);

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wr_addr == REG_ADDR_WIDTH'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!resetn) regs_q[i] <= '0;
      else         regs_q[i] <= regs_d[i];
    end
  end

  assign rd_data = regs_q[rd_addr];

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[32*i +: 32] = regs_q[i];
  end

endmodule

// File: rtl/pcie_cq_reg_completer.sv
// rtl/pcie_cq_reg_completer.sv - CQ 1-DW memory request completer with register file
// Purpose: accepts 1-DW MemRd/MemWr on the CQ stream, updates the register file,
//   returns single-beat CplD/Cpl on the CC stream; unsupported non-posted requests get UR.
// Ports: user_clk, reset (sync active-low); m_axis_cq_* request stream in;
//   s_axis_cc_* completion stream out; regs_out flattened registers; stat_ur_cnt.
module pcie_cq_reg_completer
  import pcie_tlp_pkg::*;
#(
  parameter int          C_DATA_WIDTH        = 128,
  parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int          AXI4_CQ_TUSER_WIDTH = 88,
  parameter int          AXI4_CC_TUSER_WIDTH = 33,
  parameter logic [15:0] COMPLETER_ID        = 16'h0000,
  parameter int          NUM_REGS            = 16,
  parameter int          REG_ADDR_WIDTH      = 4
) (
  input  logic                           user_clk,
  input  logic                           reset,
  input  logic [C_DATA_WIDTH-1:0]        m_axis_cq_tdata,
  input  logic [KEEP_WIDTH-1:0]          m_axis_cq_tkeep,
  input  logic [AXI4_CQ_TUSER_WIDTH-1:0] m_axis_cq_tuser,
  input  logic                           m_axis_cq_tlast,
  input  logic                           m_axis_cq_tvalid,
  output logic                           m_axis_cq_tready,
  output logic [C_DATA_WIDTH-1:0]        s_axis_cc_tdata,
  output logic [KEEP_WIDTH-1:0]          s_axis_cc_tkeep,
  output logic [AXI4_CC_TUSER_WIDTH-1:0] s_axis_cc_tuser,
  output logic                           s_axis_cc_tlast,
  output logic                           s_axis_cc_tvalid,
  input  logic                           s_axis_cc_tready,
  output logic [NUM_REGS*32-1:0]         regs_out,
  output logic [15:0]                    stat_ur_cnt
);

  cq_state_e                 state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]                be_q, be_d;
  logic                      pend_q, pend_d;
  logic                      ur_q, ur_d;
  logic [C_DATA_WIDTH-1:0]   cc_tdata_q, cc_tdata_d;
  logic [KEEP_WIDTH-1:0]     cc_tkeep_q, cc_tkeep_d;
  logic [15:0]               ur_cnt_q, ur_cnt_d;

  logic                      wr_en;
  logic [REG_ADDR_WIDTH-1:0] rd_idx;
  logic [31:0]               rd_data;
  logic                      beat, sop;
  logic [3:0]                req_type;
  logic [10:0]               dw_cnt;
  logic                      is_rd_sc, is_wr, is_ur;

  // Descriptor fields not needed here (tkeep, other tuser bits, reserved tdata)
  logic unused_inputs;
  assign unused_inputs = ^{m_axis_cq_tkeep, m_axis_cq_tuser, m_axis_cq_tdata};

  // Held low while reset is asserted so no beat appears accepted during reset.
  assign m_axis_cq_tready = reset && (state_q != ST_CPL);
  assign beat     = m_axis_cq_tvalid && m_axis_cq_tready;
  assign sop      = m_axis_cq_tuser[CQ_TUSER_SOP];
  assign req_type = m_axis_cq_tdata[CQ_REQTYPE_LSB +: 4];
  assign dw_cnt   = m_axis_cq_tdata[CQ_DWCNT_LSB +: 11];
  assign rd_idx   = m_axis_cq_tdata[REG_ADDR_WIDTH+1:2];

  assign is_rd_sc = (req_type == CQ_REQ_MEM_RD) && (dw_cnt == 11'd1);
  assign is_wr    = (req_type == CQ_REQ_MEM_WR) && (dw_cnt == 11'd1);
  assign is_ur    = ((req_type == CQ_REQ_MEM_RD) && (dw_cnt != 11'd1)) ||
                    (req_type == CQ_REQ_IO_RD) || (req_type == CQ_REQ_IO_WR) ||
                    (req_type == CQ_REQ_LOCKED_RD);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    be_d       = be_q;
    pend_d     = pend_q;
    ur_d       = ur_q;
    cc_tdata_d = cc_tdata_q;
    cc_tkeep_d = cc_tkeep_q;
    ur_cnt_d   = ur_cnt_q;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          if (sop) begin
            idx_d  = rd_idx;
            be_d   = m_axis_cq_tuser[3:0];
            pend_d = is_rd_sc || is_ur;
            ur_d   = is_ur;
            if (is_rd_sc || is_ur) begin
              // Read data is captured here, so a later write cannot alter it.
              cc_tdata_d = build_cc_desc(m_axis_cq_tdata[6:0], is_ur,
                                         m_axis_cq_tdata[CQ_REQID_LSB +: 16],
                                         m_axis_cq_tdata[CQ_TAG_LSB +: 8], COMPLETER_ID,
                                         m_axis_cq_tdata[CQ_TC_LSB +: 3],
                                         m_axis_cq_tdata[CQ_ATTR_LSB +: 3], rd_data);
              cc_tkeep_d = is_ur ? 4'h7 : 4'hF;
            end
            if (is_wr)                      state_d = ST_WR_DATA;
            else if (!m_axis_cq_tlast)      state_d = ST_DRAIN;
            else if (is_rd_sc || is_ur)     state_d = ST_CPL;
          end else begin
            // Stray continuation beat: swallow the rest of its packet.
            pend_d = 1'b0;
            if (!m_axis_cq_tlast) state_d = ST_DRAIN;
          end
        end
      end
      ST_WR_DATA: begin
        if (beat) begin
          wr_en   = 1'b1;
          pend_d  = 1'b0;
          state_d = m_axis_cq_tlast ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beat && m_axis_cq_tlast) state_d = pend_q ? ST_CPL : ST_IDLE;
      end
      ST_CPL: begin
        if (s_axis_cc_tready) begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
          if (ur_q && (ur_cnt_q != 16'hFFFF)) ur_cnt_d = ur_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      be_q       <= '0;
      pend_q     <= 1'b0;
      ur_q       <= 1'b0;
      cc_tdata_q <= '0;
      cc_tkeep_q <= '0;
      ur_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      be_q       <= be_d;
      pend_q     <= pend_d;
      ur_q       <= ur_d;
      cc_tdata_q <= cc_tdata_d;
      cc_tkeep_q <= cc_tkeep_d;
      ur_cnt_q   <= ur_cnt_d;
    end
  end

  pcie_cq_reg_file #(
    .NUM_REGS       (NUM_REGS),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_reg_file (
    .clk       (user_clk),
    .resetn    (reset),
    .wr_en     (wr_en),
    .wr_addr   (idx_q),
    .wr_be     (be_q),
    .wr_data   (m_axis_cq_tdata[31:0]),
    .rd_addr   (rd_idx),
    .rd_data   (rd_data),
    .regs_flat (regs_out)
  );

  assign s_axis_cc_tvalid = (state_q == ST_CPL);
  assign s_axis_cc_tlast  = (state_q == ST_CPL);
  assign s_axis_cc_tdata  = cc_tdata_q;
  assign s_axis_cc_tkeep  = cc_tkeep_q;
  assign s_axis_cc_tuser  = '0;
  assign stat_ur_cnt      = ur_cnt_q;

endmodule

// File: tb/tb_pcie_cq_reg_completer.sv
// tb/tb_pcie_cq_reg_completer.sv - directed self-checking bench for pcie_cq_reg_completer
module tb_pcie_cq_reg_completer;

  logic          user_clk = 1'b0;
  logic          reset;
  logic [127:0]  m_axis_cq_tdata;
  logic [3:0]    m_axis_cq_tkeep;
  logic [87:0]   m_axis_cq_tuser;
  logic          m_axis_cq_tlast;
  logic          m_axis_cq_tvalid;
  logic          m_axis_cq_tready;
  logic [127:0]  s_axis_cc_tdata;
  logic [3:0]    s_axis_cc_tkeep;
  logic [32:0]   s_axis_cc_tuser;
  logic          s_axis_cc_tlast;
  logic          s_axis_cc_tvalid;
  logic          s_axis_cc_tready;
  logic [511:0]  regs_out;
  logic [15:0]   stat_ur_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  logic [31:0] mdl [16];

  always #5 user_clk = ~user_clk;

  pcie_cq_reg_completer dut (
    .user_clk         (user_clk),
    .reset            (reset),
    .m_axis_cq_tdata  (m_axis_cq_tdata),
    .m_axis_cq_tkeep  (m_axis_cq_tkeep),
    .m_axis_cq_tuser  (m_axis_cq_tuser),
    .m_axis_cq_tlast  (m_axis_cq_tlast),
    .m_axis_cq_tvalid (m_axis_cq_tvalid),
    .m_axis_cq_tready (m_axis_cq_tready),
    .s_axis_cc_tdata  (s_axis_cc_tdata),
    .s_axis_cc_tkeep  (s_axis_cc_tkeep),
    .s_axis_cc_tuser  (s_axis_cc_tuser),
    .s_axis_cc_tlast  (s_axis_cc_tlast),
    .s_axis_cc_tvalid (s_axis_cc_tvalid),
    .s_axis_cc_tready (s_axis_cc_tready),
    .regs_out         (regs_out),
    .stat_ur_cnt      (stat_ur_cnt)
  );

  always @(posedge user_clk) if (s_axis_cc_tvalid && s_axis_cc_tready) hs_cnt <= hs_cnt + 1;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_desc(input logic [63:0] addr, input logic [10:0] dw,
                                           input logic [3:0] rtype, input logic [15:0] rid,
                                           input logic [7:0] tag, input logic [2:0] tc,
                                           input logic [2:0] attr);
    logic [127:0] d;
    d = '0;
    d[63:2]    = addr[63:2];
    d[74:64]   = dw;
    d[78:75]   = rtype;
    d[95:80]   = rid;
    d[103:96]  = tag;
    d[123:121] = tc;
    d[126:124] = attr;
    return d;
  endfunction

  function automatic logic [127:0] exp_cc(input logic [6:0] la, input logic ur,
                                          input logic [15:0] rid, input logic [7:0] tag,
                                          input logic [2:0] tc, input logic [2:0] attr,
                                          input logic [31:0] data);
    logic [127:0] d;
    d = '0;
    d[6:0]    = la;
    d[28:16]  = 13'd4;
    d[42:32]  = ur ? 11'd0 : 11'd1;
    d[45:43]  = ur ? 3'b001 : 3'b000;
    d[63:48]  = rid;
    d[71:64]  = tag;
    d[87:72]  = 16'h0000;
    d[91:89]  = tc;
    d[94:92]  = attr;
    d[127:96] = ur ? 32'd0 : data;
    return d;
  endfunction

  function automatic logic [511:0] mdl_flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[32*i +: 32] = mdl[i];
    return f;
  endfunction

  task automatic send_beat(input logic [127:0] d, input logic [3:0] be, input logic sop,
                           input logic last);
    int n;
    m_axis_cq_tdata  = d;
    m_axis_cq_tkeep  = 4'hF;
    m_axis_cq_tuser  = '0;
    m_axis_cq_tuser[3:0] = be;
    m_axis_cq_tuser[40]  = sop;
    m_axis_cq_tlast  = last;
    m_axis_cq_tvalid = 1'b1;
    n = 0;
    while (!m_axis_cq_tready && n < 50) begin
      @(negedge user_clk);
      n++;
    end
    if (!m_axis_cq_tready) check_eq("cq_accept_timeout", 0, 1);
    else begin
      @(posedge user_clk);
      @(negedge user_clk);
    end
  endtask

  task automatic mem_wr(input logic [63:0] addr, input logic [3:0] be, input logic [31:0] data,
                        input logic [10:0] dw, input bit keep_valid);
    send_beat(mk_desc(addr, dw, 4'b0001, 16'h0001, 8'h00, 3'd0, 3'd0), be, 1'b1, 1'b0);
    send_beat({96'h0, data}, 4'h0, 1'b0, 1'b1);
    if (!keep_valid) m_axis_cq_tvalid = 1'b0;
  endtask

  task automatic mem_rd(input logic [63:0] addr, input logic [10:0] dw, input logic [15:0] rid,
                        input logic [7:0] tag, input logic [2:0] tc, input logic [2:0] attr);
    send_beat(mk_desc(addr, dw, 4'b0000, rid, tag, tc, attr), 4'hF, 1'b1, 1'b1);
    m_axis_cq_tvalid = 1'b0;
  endtask

  task automatic wait_cc(output logic [127:0] d, output logic [3:0] k, output logic l);
    int n;
    n = 0;
    while (!s_axis_cc_tvalid && n < 20) begin
      @(negedge user_clk);
      n++;
    end
    if (!s_axis_cc_tvalid) check_eq("cc_timeout", 0, 1);
    d = s_axis_cc_tdata;
    k = s_axis_cc_tkeep;
    l = s_axis_cc_tlast;
    s_axis_cc_tready = 1'b1;
    @(posedge user_clk);
    @(negedge user_clk);
    s_axis_cc_tready = 1'b0;
  endtask

  logic [127:0] cd;
  logic [3:0]   ck;
  logic         cl;
  int           hs0;
  bit           saw_valid;

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    reset            = 1'b0;
    m_axis_cq_tdata  = '0;
    m_axis_cq_tkeep  = '0;
    m_axis_cq_tuser  = '0;
    m_axis_cq_tlast  = 1'b0;
    m_axis_cq_tvalid = 1'b0;
    s_axis_cc_tready = 1'b0;
    repeat (3) @(negedge user_clk);

    check_eq("rst_cq_tready", m_axis_cq_tready, 0);
    check_eq("rst_cc_tvalid", s_axis_cc_tvalid, 0);
    check_eq("rst_cc_tdata", s_axis_cc_tdata, 0);
    check_eq("rst_regs", regs_out[127:0], 0);
    check_eq("rst_ur_cnt", stat_ur_cnt, 0);
    reset = 1'b1;
    @(negedge user_clk);
    check_eq("idle_cq_tready", m_axis_cq_tready, 1);

    // Full-word write then read back
    mem_wr(64'h08, 4'hF, 32'hDEADBEEF, 11'd1, 1'b0);
    mdl[2] = 32'hDEADBEEF;
    check_eq("wr_reg2", regs_out[95:64], 32'hDEADBEEF);
    mem_rd(64'h08, 11'd1, 16'hABCD, 8'h12, 3'd2, 3'd5);
    check_eq("rd_latency", s_axis_cc_tvalid, 1);
    wait_cc(cd, ck, cl);
    check_eq("rd_cpld", cd, exp_cc(7'h08, 1'b0, 16'hABCD, 8'h12, 3'd2, 3'd5, 32'hDEADBEEF));
    check_eq("rd_tkeep", ck, 4'hF);
    check_eq("rd_tlast", cl, 1);

    // Partial byte-enable write
    mem_wr(64'h04, 4'b0101, 32'h11223344, 11'd1, 1'b0);
    mdl[1] = 32'h00220044;
    check_eq("be_reg1", regs_out[63:32], 32'h00220044);

    // Bad-length read gets UR
    mem_rd(64'h08, 11'd2, 16'h0042, 8'h05, 3'd0, 3'd0);
    wait_cc(cd, ck, cl);
    check_eq("ur_cpl", cd, exp_cc(7'h08, 1'b1, 16'h0042, 8'h05, 3'd0, 3'd0, 32'h0));
    check_eq("ur_tkeep", ck, 4'h7);
    check_eq("ur_cnt1", stat_ur_cnt, 1);

    // Multi-dword write is dropped silently
    mem_wr(64'h0C, 4'hF, 32'h55555555, 11'd4, 1'b0);
    saw_valid = 1'b0;
    repeat (5) begin
      @(negedge user_clk);
      if (s_axis_cc_tvalid) saw_valid = 1'b1;
    end
    check_eq("wr4_no_cc", saw_valid, 0);
    check_eq("wr4_regs", regs_out, mdl_flat());

    // Back-pressure on CC
    hs0 = hs_cnt;
    mem_rd(64'h08, 11'd1, 16'h1234, 8'h21, 3'd1, 3'd1);
    m_axis_cq_tdata  = mk_desc(64'h04, 11'd1, 4'b0000, 16'h1, 8'h1, 3'd0, 3'd0);
    m_axis_cq_tuser  = 88'h100_0000_000F;
    m_axis_cq_tlast  = 1'b1;
    m_axis_cq_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_cc_tdata", s_axis_cc_tdata,
               exp_cc(7'h08, 1'b0, 16'h1234, 8'h21, 3'd1, 3'd1, 32'hDEADBEEF));
      check_eq("stall_cq_tready", {s_axis_cc_tvalid, m_axis_cq_tready}, 2'b10);
      @(negedge user_clk);
    end
    m_axis_cq_tvalid = 1'b0;
    wait_cc(cd, ck, cl);
    repeat (3) @(negedge user_clk);
    check_eq("stall_one_hs", hs_cnt - hs0, 1);

    // Address wrap, write immediately followed by read of the aliased register
    mem_wr(64'h44, 4'hF, 32'hCAFEF00D, 11'd1, 1'b1);
    mdl[1] = 32'hCAFEF00D;
    mem_rd(64'h04, 11'd1, 16'h0077, 8'h33, 3'd0, 3'd0);
    wait_cc(cd, ck, cl);
    check_eq("wrap_cpld", cd, exp_cc(7'h04, 1'b0, 16'h0077, 8'h33, 3'd0, 3'd0, 32'hCAFEF00D));
    check_eq("wrap_regs", regs_out, mdl_flat());

    // Reset while a completion is pending
    mem_rd(64'h08, 11'd1, 16'h0099, 8'h44, 3'd0, 3'd0);
    check_eq("pre_rst_valid", s_axis_cc_tvalid, 1);
    reset = 1'b0;
    @(negedge user_clk);
    check_eq("mid_rst_valid", s_axis_cc_tvalid, 0);
    check_eq("mid_rst_regs", regs_out, 0);
    check_eq("mid_rst_ur_cnt", stat_ur_cnt, 0);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    @(negedge user_clk);
    mem_rd(64'h08, 11'd1, 16'h00AA, 8'h55, 3'd0, 3'd0);
    wait_cc(cd, ck, cl);
    check_eq("post_rst_cpld", cd, exp_cc(7'h08, 1'b0, 16'h00AA, 8'h55, 3'd0, 3'd0, 32'h0));
    check_eq("post_rst_tkeep", ck, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
